// File: rtl/alu_rs_if.sv
// Bundle between the decoder/broadcast side and the ALU reservation station.
// Issue is accepted on an edge where issue_valid=1 and rs_full=0; cal_signal is a one-cycle dispatch strobe with no backpressure.
interface alu_rs_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 issue_valid;
  logic [3:0]           issue_opcode;
  logic [31:0]          issue_vj;
  logic                 issue_qj_busy;
  logic [ROB_WIDTH-1:0] issue_qj;
  logic [31:0]          issue_vk;
  logic                 issue_qk_busy;
  logic [ROB_WIDTH-1:0] issue_qk;
  logic [ROB_WIDTH-1:0] issue_tag;
  logic                 rs_full;
  logic                 alu_done;
  logic [31:0]          alu_value;
  logic [ROB_WIDTH-1:0] alu_tag;
  logic                 lsb_done;
  logic [31:0]          lsb_value;
  logic [ROB_WIDTH-1:0] lsb_tag;
  logic                 cal_signal;
  logic [3:0]           opcode;
  logic [31:0]          lhs;
  logic [31:0]          rhs;
  logic [ROB_WIDTH-1:0] tag;

  modport master (
    output issue_valid, issue_opcode, issue_vj, issue_qj_busy, issue_qj,
           issue_vk, issue_qk_busy, issue_qk, issue_tag,
           alu_done, alu_value, alu_tag, lsb_done, lsb_value, lsb_tag,
    input  rs_full, cal_signal, opcode, lhs, rhs, tag
  );

  modport slave (
    input  issue_valid, issue_opcode, issue_vj, issue_qj_busy, issue_qj,
           issue_vk, issue_qk_busy, issue_qk, issue_tag,
           alu_done, alu_value, alu_tag, lsb_done, lsb_value, lsb_tag,
    output rs_full, cal_signal, opcode, lhs, rhs, tag
  );
endinterface

// File: rtl/alu_rs.sv
// Reservation station in front of the integer ALU: buffers tagged ops, snoops
// ALU/LSB result broadcasts for missing operands, dispatches one ready op per cycle.
module alu_rs #(
  parameter int ROB_WIDTH = 4,
  parameter int RS_WIDTH  = 3
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     clear_signal,
  alu_rs_if.slave  bus
);
  localparam int N = 1 << RS_WIDTH;

  logic [N-1:0]         busy;
  logic [3:0]           op   [N];
  logic [31:0]          vj   [N];
  logic [31:0]          vk   [N];
  logic [ROB_WIDTH-1:0] qj   [N];
  logic [ROB_WIDTH-1:0] qk   [N];
  logic [ROB_WIDTH-1:0] dest [N];
  logic [N-1:0]         rj;
  logic [N-1:0]         rk;

  logic                 cal_q;
  logic [3:0]           opcode_q;
  logic [31:0]          lhs_q;
  logic [31:0]          rhs_q;
  logic [ROB_WIDTH-1:0] tag_q;

  logic                 full;
  logic [RS_WIDTH-1:0]  free_idx;
  logic [RS_WIDTH-1:0]  ready_idx;
  logic                 has_ready;
  logic [31:0]          fwd_vj, fwd_vk;
  logic                 fwd_rj, fwd_rk;

  assign full           = &busy;
  assign bus.rs_full    = full;
  assign bus.cal_signal = cal_q;
  assign bus.opcode     = opcode_q;
  assign bus.lhs        = lhs_q;
  assign bus.rhs        = rhs_q;
  assign bus.tag        = tag_q;

  // Scanning downward leaves the lowest matching index selected.
  always_comb begin
    free_idx  = '0;
    ready_idx = '0;
    has_ready = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = RS_WIDTH'(i);
      if (busy[i] && !rj[i] && !rk[i]) begin
        ready_idx = RS_WIDTH'(i);
        has_ready = 1'b1;
      end
    end
  end

  // Operands produced on the same cycle they are issued are taken straight from the broadcast.
  always_comb begin
    fwd_vj = bus.issue_vj;
    fwd_rj = bus.issue_qj_busy;
    fwd_vk = bus.issue_vk;
    fwd_rk = bus.issue_qk_busy;
    if (bus.issue_qj_busy) begin
      if (bus.alu_done && bus.alu_tag == bus.issue_qj) begin
        fwd_vj = bus.alu_value;
        fwd_rj = 1'b0;
      end else if (bus.lsb_done && bus.lsb_tag == bus.issue_qj) begin
        fwd_vj = bus.lsb_value;
        fwd_rj = 1'b0;
      end
    end
    if (bus.issue_qk_busy) begin
      if (bus.alu_done && bus.alu_tag == bus.issue_qk) begin
        fwd_vk = bus.alu_value;
        fwd_rk = 1'b0;
      end else if (bus.lsb_done && bus.lsb_tag == bus.issue_qk) begin
        fwd_vk = bus.lsb_value;
        fwd_rk = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy     <= '0;
      rj       <= '0;
      rk       <= '0;
      cal_q    <= 1'b0;
      opcode_q <= '0;
      lhs_q    <= '0;
      rhs_q    <= '0;
      tag_q    <= '0;
      for (int i = 0; i < N; i++) begin
        op[i]   <= '0;
        vj[i]   <= '0;
        vk[i]   <= '0;
        qj[i]   <= '0;
        qk[i]   <= '0;
        dest[i] <= '0;
      end
    end else if (rdy_in) begin
      if (clear_signal) begin
        busy  <= '0;
        cal_q <= 1'b0;
      end else begin
        // Wakeup touches only busy entries; issue only a free one, so they never collide.
        for (int i = 0; i < N; i++) begin
          if (busy[i] && rj[i]) begin
            if (bus.alu_done && bus.alu_tag == qj[i]) begin
              vj[i] <= bus.alu_value;
              rj[i] <= 1'b0;
            end else if (bus.lsb_done && bus.lsb_tag == qj[i]) begin
              vj[i] <= bus.lsb_value;
              rj[i] <= 1'b0;
            end
          end
          if (busy[i] && rk[i]) begin
            if (bus.alu_done && bus.alu_tag == qk[i]) begin
              vk[i] <= bus.alu_value;
              rk[i] <= 1'b0;
            end else if (bus.lsb_done && bus.lsb_tag == qk[i]) begin
              vk[i] <= bus.lsb_value;
              rk[i] <= 1'b0;
            end
          end
        end

        if (has_ready) begin
          cal_q           <= 1'b1;
          opcode_q        <= op[ready_idx];
          lhs_q           <= vj[ready_idx];
          rhs_q           <= vk[ready_idx];
          tag_q           <= dest[ready_idx];
          busy[ready_idx] <= 1'b0;
        end else begin
          cal_q <= 1'b0;
        end

        if (bus.issue_valid && !full) begin
          busy[free_idx] <= 1'b1;
          op[free_idx]   <= bus.issue_opcode;
          vj[free_idx]   <= fwd_vj;
          rj[free_idx]   <= fwd_rj;
          qj[free_idx]   <= bus.issue_qj;
          vk[free_idx]   <= fwd_vk;
          rk[free_idx]   <= fwd_rk;
          qk[free_idx]   <= bus.issue_qk;
          dest[free_idx] <= bus.issue_tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: a one-cycle-per-row vector table followed by
// hand-written sequences for fill/drain, flush, stall and async reset.
module tb_alu_rs;
  localparam int RW = 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic clear_signal = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  alu_rs_if #(.ROB_WIDTH(RW)) bus ();

  alu_rs #(.ROB_WIDTH(RW), .RS_WIDTH(3)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear_signal (clear_signal),
    .bus          (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic          iv;
    logic [3:0]    op;
    logic [31:0]   vj;
    logic          qjb;
    logic [RW-1:0] qj;
    logic [31:0]   vk;
    logic          qkb;
    logic [RW-1:0] qk;
    logic [RW-1:0] itag;
    logic          ad;
    logic [31:0]   av;
    logic [RW-1:0] at;
    logic          ld;
    logic [31:0]   lv;
    logic [RW-1:0] lt;
    logic          e_cal;
    logic [3:0]    e_op;
    logic [31:0]   e_lhs;
    logic [31:0]   e_rhs;
    logic [RW-1:0] e_tag;
    logic          e_full;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic cal, input logic [3:0] op,
                         input logic [31:0] l, input logic [31:0] r,
                         input logic [RW-1:0] t, input logic full);
    chk({nm, ".cal"},  32'(bus.cal_signal), 32'(cal));
    chk({nm, ".op"},   32'(bus.opcode),     32'(op));
    chk({nm, ".lhs"},  bus.lhs,             l);
    chk({nm, ".rhs"},  bus.rhs,             r);
    chk({nm, ".tag"},  32'(bus.tag),        32'(t));
    chk({nm, ".full"}, 32'(bus.rs_full),    32'(full));
  endtask

  task automatic idle();
    bus.issue_valid   = 1'b0;
    bus.issue_opcode  = '0;
    bus.issue_vj      = '0;
    bus.issue_qj_busy = 1'b0;
    bus.issue_qj      = '0;
    bus.issue_vk      = '0;
    bus.issue_qk_busy = 1'b0;
    bus.issue_qk      = '0;
    bus.issue_tag     = '0;
    bus.alu_done      = 1'b0;
    bus.alu_value     = '0;
    bus.alu_tag       = '0;
    bus.lsb_done      = 1'b0;
    bus.lsb_value     = '0;
    bus.lsb_tag       = '0;
    clear_signal      = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic qjb,
                       input logic [RW-1:0] qj, input logic [31:0] vk, input logic qkb,
                       input logic [RW-1:0] qk, input logic [RW-1:0] t);
    bus.issue_valid   = 1'b1;
    bus.issue_opcode  = op;
    bus.issue_vj      = vj;
    bus.issue_qj_busy = qjb;
    bus.issue_qj      = qj;
    bus.issue_vk      = vk;
    bus.issue_qk_busy = qkb;
    bus.issue_qk      = qk;
    bus.issue_tag     = t;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    // iv op vj qjb qj vk qkb qk itag | ad av at | ld lv lt | cal op lhs rhs tag full
    tbl[0]  = '{1, 4, 5, 0, 0, 7, 0, 0, 3,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 4, 5, 7, 3, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 4, 5, 7, 3, 0};
    tbl[3]  = '{1, 5, 0, 1, 2, 1, 0, 0, 4,  0, 0, 0,  0, 0, 0,  0, 4, 5, 7, 3, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 10, 2, 0, 0, 0,  0, 4, 5, 7, 3, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 5, 10, 1, 4, 0};
    tbl[6]  = '{1, 7, 'h11, 0, 0, 0, 1, 6, 5, 0, 0, 0, 1, 'hFFFF0000, 6, 0, 5, 10, 1, 4, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 7, 'h11, 'hFFFF0000, 5, 0};
    tbl[8]  = '{1, 2, 0, 1, 9, 3, 0, 0, 6,  1, 'hAAAA, 9, 1, 'hBBBB, 9, 0, 7, 'h11, 'hFFFF0000, 5, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 2, 'hAAAA, 3, 6, 0};
    tbl[10] = '{1, 3, 0, 1, 1, 2, 0, 0, 7,  0, 0, 0,  0, 0, 0,  0, 2, 'hAAAA, 3, 6, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 'h123, 1, 1, 'h456, 1, 0, 2, 'hAAAA, 3, 6, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 3, 'h123, 2, 7, 0};
    tbl[13] = '{1, 4, 1, 0, 0, 1, 0, 0, 8,  0, 0, 0,  0, 0, 0,  0, 3, 'h123, 2, 7, 0};
    tbl[14] = '{1, 6, 2, 0, 0, 2, 0, 0, 9,  0, 0, 0,  0, 0, 0,  1, 4, 1, 1, 8, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 6, 2, 2, 9, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 6, 2, 2, 9, 0};

    idle();
    step();
    step();
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    rst_in = 1'b1;

    for (int k = 0; k < 17; k++) begin
      bus.issue_valid   = tbl[k].iv;
      bus.issue_opcode  = tbl[k].op;
      bus.issue_vj      = tbl[k].vj;
      bus.issue_qj_busy = tbl[k].qjb;
      bus.issue_qj      = tbl[k].qj;
      bus.issue_vk      = tbl[k].vk;
      bus.issue_qk_busy = tbl[k].qkb;
      bus.issue_qk      = tbl[k].qk;
      bus.issue_tag     = tbl[k].itag;
      bus.alu_done      = tbl[k].ad;
      bus.alu_value     = tbl[k].av;
      bus.alu_tag       = tbl[k].at;
      bus.lsb_done      = tbl[k].ld;
      bus.lsb_value     = tbl[k].lv;
      bus.lsb_tag       = tbl[k].lt;
      step();
      chk_out($sformatf("vec%0d", k), tbl[k].e_cal, tbl[k].e_op, tbl[k].e_lhs,
              tbl[k].e_rhs, tbl[k].e_tag, tbl[k].e_full);
    end
    idle();

    // Fill all eight entries waiting on tag 12, try a ninth, then drain in index order.
    for (int i = 0; i < 8; i++) begin
      issue(4'(i + 1), 0, 1, 12, 32'(i * 16 + 1), 0, 0, RW'(i));
      step();
      chk($sformatf("fill%0d.full", i), 32'(bus.rs_full), (i == 7) ? 1 : 0);
    end
    issue(4'hF, 32'h55, 0, 0, 32'h66, 0, 0, 15);
    step();
    chk("ninth.full", 32'(bus.rs_full), 1);
    chk("ninth.cal", 32'(bus.cal_signal), 0);
    idle();
    bus.alu_done  = 1'b1;
    bus.alu_tag   = 12;
    bus.alu_value = 32'hCAFE;
    step();
    chk("wake.full", 32'(bus.rs_full), 1);
    chk("wake.cal", 32'(bus.cal_signal), 0);
    idle();
    for (int i = 0; i < 8; i++) begin
      step();
      chk_out($sformatf("drain%0d", i), 1, 4'(i + 1), 32'hCAFE, 32'(i * 16 + 1), RW'(i), 0);
    end
    step();
    chk("drain_end.cal", 32'(bus.cal_signal), 0);

    // Flush with a concurrent issue: entries vanish and the issue is dropped.
    for (int i = 0; i < 4; i++) begin
      issue(4'h1, 0, 1, 13, 0, 0, 0, RW'(i));
      step();
    end
    issue(4'h2, 32'h77, 0, 0, 32'h88, 0, 0, 11);
    clear_signal = 1'b1;
    step();
    chk("flush.cal", 32'(bus.cal_signal), 0);
    chk("flush.full", 32'(bus.rs_full), 0);
    idle();
    bus.alu_done = 1'b1;
    bus.alu_tag  = 13;
    step();
    idle();
    step();
    chk("flush_post1.cal", 32'(bus.cal_signal), 0);
    step();
    chk("flush_post2.cal", 32'(bus.cal_signal), 0);

    // Stall while an op is ready: nothing moves until rdy_in returns.
    issue(4'h9, 32'h99, 0, 0, 32'h77, 0, 0, 10);
    step();
    idle();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("stall%0d", i), 0, 4'h8, 32'hCAFE, 32'h71, 7, 0);
    end
    rdy_in = 1'b1;
    step();
    chk_out("resume", 1, 4'h9, 32'h99, 32'h77, 10, 0);
    rdy_in = 1'b0;
    step();
    chk_out("hold_strobe", 1, 4'h9, 32'h99, 32'h77, 10, 0);
    rdy_in = 1'b1;

    // Async reset mid-cycle with three busy entries and a strobe in flight.
    for (int i = 0; i < 3; i++) begin
      issue(4'h3, 0, 1, 14, 0, 0, 0, RW'(i));
      step();
    end
    issue(4'hA, 32'h1234, 0, 0, 32'h5678, 0, 0, 12);
    step();
    idle();
    step();
    chk("pre_reset.cal", 32'(bus.cal_signal), 1);
    #2;
    rst_in = 1'b0;
    #1;
    chk_out("async_reset", 0, 0, 0, 0, 0, 0);
    step();
    rst_in = 1'b1;
    issue(4'hB, 32'h3, 0, 0, 32'h4, 0, 0, 5);
    step();
    idle();
    step();
    chk_out("post_reset", 1, 4'hB, 32'h3, 32'h4, 5, 0);
    step();
    chk("post_reset_end.cal", 32'(bus.cal_signal), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station directly upstream of the integer ALU.
- Buffers up to 2^RS_WIDTH decoded ALU/branch operations tagged by ROB index.
- Captures missing operands from the ALU and LSB result broadcasts.
- Dispatches at most one fully-ready entry per cycle to the ALU on the cal_signal/opcode/lhs/rhs/tag interface.

Parameters:
ROB_WIDTH, 4, width of ROB tags (must match ALU ROB_WIDTH)
RS_WIDTH, 3, log2 of entry count (default 8 entries)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  ready; when low, all state and outputs hold
clear_signal  input  1  misprediction flush
issue_valid  input  1  decoder presents a new op this cycle
issue_opcode  input  4  ALU opcode (NOP..JALR encoding, 0..15)
issue_vj  input  32  operand j value (valid when issue_qj_busy=0)
issue_qj_busy  input  1  operand j awaits ROB tag issue_qj
issue_qj  input  ROB_WIDTH  producer tag for operand j
issue_vk  input  32  operand k value
issue_qk_busy  input  1  operand k awaits tag issue_qk
issue_qk  input  ROB_WIDTH  producer tag for operand k
issue_tag  input  ROB_WIDTH  destination ROB tag
rs_full  output  1  no free entry (combinational from registered state)
alu_done  input  1  ALU result broadcast valid
alu_value  input  32  ALU result
alu_tag  input  ROB_WIDTH  ALU result tag
lsb_done  input  1  LSB result broadcast valid
lsb_value  input  32  LSB result
lsb_tag  input  ROB_WIDTH  LSB result tag
cal_signal  output  1  registered dispatch strobe to ALU
opcode  output  4  dispatched opcode
lhs  output  32  dispatched operand j
rhs  output  32  dispatched operand k
tag  output  ROB_WIDTH  dispatched destination tag

Behaviour:
- Reset (rst_in low, async): all entries not busy; cal_signal=0, opcode=0 (NOP), lhs=0, rhs=0, tag=0.
- Entry fields: busy, op, vj, qj, rj (j pending), vk, qk, rk, dest.
- rdy_in=0: no state change; outputs hold.
- All actions below require rdy_in=1.
- Flush: clear_signal=1 at an edge → every busy bit cleared, cal_signal<=0; issue and dispatch suppressed that cycle.
- rs_full=1 iff all 2^RS_WIDTH entries are busy in current registered state.
- Issue:
  - Accepted iff issue_valid & ~rs_full; ignored otherwise (no state change).
  - Target is the lowest-index non-busy entry in the current state.
  - An entry freed by dispatch in the same cycle is not reusable until the next cycle.
- Issue-time forwarding: if issue_qj_busy and (alu_done & alu_tag==issue_qj) or (lsb_done & lsb_tag==issue_qj), store the matching value with rj=0. Same rule for k.
- Wakeup: each busy entry with rj=1 and qj matching a valid broadcast captures the value and clears rj. Same rule for k.
- Broadcast priority: if both broadcasts match the same operand (illegal by tag uniqueness), ALU wins.
- Ready: busy & ~rj & ~rk, evaluated on registered state only; values captured this cycle count next cycle.
- Dispatch:
  - Select lowest-index ready entry.
  - Next edge: cal_signal<=1, opcode/lhs/rhs/tag <= op/vj/vk/dest; entry busy<=0.
  - No ready entry: cal_signal<=0; opcode/lhs/rhs/tag hold.
- Latency:
  - Op issued ready at edge N is dispatch-eligible after N; cal_signal high after edge N+1; ALU done_result after N+2.
  - Op woken by broadcast at edge M: cal_signal after M+1.
- Throughput: one dispatch per cycle; back-to-back dependent ops are 2-cycle spaced (ALU result → wakeup → dispatch).
- Simultaneous issue and dispatch in the same cycle are both performed.
- Wakeup and dispatch are independent; an entry cannot wake and dispatch in one cycle.
- Operand widths: fixed 32-bit; no arithmetic in this block.

Test Plan:
- Reset low mid-operation with 3 busy entries → immediately cal_signal=0, opcode=0, rs_full=0; after release, first issue goes to entry 0.
- Issue ADD vj=5 vk=7 (both ready), tag=3 at edge N → after N+1: cal_signal=1, opcode=4, lhs=5, rhs=7, tag=3; after N+2: cal_signal=0.
- Issue SUB with qj_busy, qj=2, vk=1; later alu_done, alu_tag=2, alu_value=10 → next edge captures; following edge dispatches lhs=10, rhs=1.
- Issue with qk_busy, qk=6 in the same cycle as lsb_done, lsb_tag=6, lsb_value=0xFFFF0000 → entry stored ready; dispatches with rhs=0xFFFF0000 one cycle later.
- Fill all 8 entries with blocked ops → rs_full=1; a 9th issue_valid is ignored. Broadcast the shared tag → entries dispatch one per cycle, lowest index first; rs_full drops after the first dispatch edge.
- 4 busy entries, clear_signal=1 together with issue_valid → all entries empty, cal_signal=0, issue dropped; rdy_in=0 for 3 cycles during a pending dispatch → outputs frozen, dispatch resumes when rdy_in returns high.
